// File: rtl/pipeline_control.sv
// Pipeline sequencer: owns the decode/EX/WB instruction slots, gates the PC, and runs HALTED/RUN/FLUSH/DRAIN.
// Optional feature macro: PIPECTL_PERF_CNT_EN adds stall_count/flush_count performance counters.
module pipeline_control #(
  parameter logic [15:0] NOP_WORD    = 16'hC0E0,
  parameter int          FLUSH_DEPTH = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] fetch_word,
  input  logic        branch_taken,
  output logic [15:0] COMMAND,
  output logic [15:0] BeforeCOMMAND,
  output logic [15:0] TwoBeforeCOMMAND,
  output logic        pc_en,
  output logic        pc_load_sel,
  output logic        stall,
  output logic        flush,
  output logic        halted
`ifdef PIPECTL_PERF_CNT_EN
  ,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
`endif
);

  localparam logic [1:0] ST_HALTED = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  // Terminal counts: FLUSH lasts FLUSH_DEPTH-1 cycles, DRAIN lasts 2 cycles.
  localparam logic [1:0] FLUSH_TERM = 2'(FLUSH_DEPTH - 2);
  localparam logic [1:0] DRAIN_TERM = 2'd1;

  logic [1:0]  state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [15:0] cmd_reg, cmd_next;
  logic [15:0] before_reg, before_next;
  logic [15:0] two_before_reg, two_before_next;

  logic        shift_en;
  logic [15:0] shift_word;
  logic        load_use;
  logic        branch_op;
  logic        halt_op;

  // Load in EX whose destination is read by the word in decode.
  assign load_use = (before_reg[15:14] == 2'b00) &&
                    ((cmd_reg[15:14] == 2'b11) || (cmd_reg[15:14] == 2'b01)) &&
                    ((cmd_reg[10:8] == before_reg[13:11]) || (cmd_reg[13:11] == before_reg[13:11]));

  assign branch_op = (cmd_reg[15:11] == 5'b10100) || (cmd_reg[15:11] == 5'b10111);
  assign halt_op   = (cmd_reg[15:14] == 2'b11) && (cmd_reg[7:4] == 4'b1111);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    shift_en        = 1'b0;
    shift_word      = NOP_WORD;
    cmd_next        = cmd_reg;
    before_next     = before_reg;
    two_before_next = two_before_reg;
    pc_en           = 1'b0;
    pc_load_sel     = 1'b0;
    stall           = 1'b0;
    flush           = 1'b0;

    case (state_reg)
      ST_HALTED: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (load_use) begin
          stall           = 1'b1;
          before_next     = NOP_WORD;
          two_before_next = before_reg;
        end else if (branch_op && branch_taken) begin
          pc_en       = 1'b1;
          pc_load_sel = 1'b1;
          flush       = 1'b1;
          shift_en    = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_next = ST_FLUSH;
            cnt_next   = 2'd0;
          end
        end else if (halt_op) begin
          shift_en   = 1'b1;
          state_next = ST_DRAIN;
          cnt_next   = 2'd0;
        end else begin
          pc_en      = 1'b1;
          shift_en   = 1'b1;
          shift_word = fetch_word;
        end
      end
      ST_FLUSH: begin
        pc_en    = 1'b1;
        flush    = 1'b1;
        shift_en = 1'b1;
        if (cnt_reg == FLUSH_TERM) state_next = ST_RUN;
        else                       cnt_next   = cnt_reg + 2'd1;
      end
      ST_DRAIN: begin
        shift_en = 1'b1;
        if (cnt_reg == DRAIN_TERM) state_next = ST_HALTED;
        else                       cnt_next   = cnt_reg + 2'd1;
      end
      default: state_next = ST_HALTED;
    endcase

    if (shift_en) begin
      two_before_next = before_reg;
      before_next     = cmd_reg;
      cmd_next        = shift_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_HALTED;
      cnt_reg        <= 2'd0;
      cmd_reg        <= NOP_WORD;
      before_reg     <= NOP_WORD;
      two_before_reg <= NOP_WORD;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      cmd_reg        <= cmd_next;
      before_reg     <= before_next;
      two_before_reg <= two_before_next;
    end
  end

  assign COMMAND          = cmd_reg;
  assign BeforeCOMMAND    = before_reg;
  assign TwoBeforeCOMMAND = two_before_reg;
  assign halted           = (state_reg == ST_HALTED);

`ifdef PIPECTL_PERF_CNT_EN
  logic [15:0] stall_count_reg;
  logic [15:0] flush_count_reg;

  // Free-running event counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_reg <= 16'd0;
      flush_count_reg <= 16'd0;
    end else begin
      stall_count_reg <= stall_count_reg + {15'd0, stall};
      flush_count_reg <= flush_count_reg + {15'd0, flush};
    end
  end

  assign stall_count = stall_count_reg;
  assign flush_count = flush_count_reg;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Randomized self-checking bench for pipeline_control against a slot-queue reference model.
// Build with PIPECTL_PERF_CNT_EN defined to also check the performance counters.
module tb_pipeline_control;

  localparam logic [15:0] NOP   = 16'hC0E0;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] fetch_word;
  logic        branch_taken;
  logic [15:0] COMMAND;
  logic [15:0] BeforeCOMMAND;
  logic [15:0] TwoBeforeCOMMAND;
  logic        pc_en;
  logic        pc_load_sel;
  logic        stall;
  logic        flush;
  logic        halted;
`ifdef PIPECTL_PERF_CNT_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  pipeline_control #(.NOP_WORD(NOP), .FLUSH_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .fetch_word       (fetch_word),
    .branch_taken     (branch_taken),
    .COMMAND          (COMMAND),
    .BeforeCOMMAND    (BeforeCOMMAND),
    .TwoBeforeCOMMAND (TwoBeforeCOMMAND),
    .pc_en            (pc_en),
    .pc_load_sel      (pc_load_sel),
    .stall            (stall),
    .flush            (flush),
    .halted           (halted)
`ifdef PIPECTL_PERF_CNT_EN
    ,
    .stall_count      (stall_count),
    .flush_count      (flush_count)
`endif
  );

  // Reference model: pipe[0]=decode, pipe[1]=EX, pipe[2]=WB, plus countdowns of pending NOP cycles.
  logic [15:0] m_pipe [3];
  bit          m_halted;
  int          m_flush_left, m_drain_left;
  logic [15:0] m_scnt, m_fcnt;

  logic [15:0] n_pipe [3];
  bit          n_halted;
  int          n_flush_left, n_drain_left;
  logic [15:0] n_scnt, n_fcnt;

  bit e_pcen, e_sel, e_stall, e_flush, e_halted;

  logic [15:0] s_cmd, s_bef, s_two;
  logic        s_pcen, s_sel, s_stall, s_flush, s_halted;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit reads_loaded_reg(input logic [15:0] c, input logic [15:0] b);
    bit is_load   = (b[15:14] == 2'b00);
    bit is_reader = (c[15:14] == 2'b11) || (c[15:14] == 2'b01);
    return is_load && is_reader && ((c[10:8] == b[13:11]) || (c[13:11] == b[13:11]));
  endfunction

  task automatic push(input logic [15:0] w);
    n_pipe[2] = m_pipe[1];
    n_pipe[1] = m_pipe[0];
    n_pipe[0] = w;
  endtask

  task automatic model_eval(input bit st, input logic [15:0] fw, input bit bt);
    logic [15:0] c;
    c = m_pipe[0];
    n_pipe = m_pipe;
    n_halted = m_halted;
    n_flush_left = m_flush_left;
    n_drain_left = m_drain_left;
    e_pcen = 0; e_sel = 0; e_stall = 0; e_flush = 0;
    e_halted = m_halted;
    if (m_halted) begin
      if (st) n_halted = 0;
    end else if (m_drain_left > 0) begin
      push(NOP);
      n_drain_left = m_drain_left - 1;
      if (n_drain_left == 0) n_halted = 1;
    end else if (m_flush_left > 0) begin
      e_pcen = 1; e_flush = 1;
      push(NOP);
      n_flush_left = m_flush_left - 1;
    end else if (reads_loaded_reg(c, m_pipe[1])) begin
      e_stall = 1;
      n_pipe[2] = m_pipe[1];
      n_pipe[1] = NOP;
    end else if ((c[15:11] == 5'b10100 || c[15:11] == 5'b10111) && bt) begin
      e_pcen = 1; e_sel = 1; e_flush = 1;
      push(NOP);
      n_flush_left = DEPTH - 1;
    end else if (c[15:14] == 2'b11 && c[7:4] == 4'hF) begin
      push(NOP);
      n_drain_left = 2;
    end else begin
      e_pcen = 1;
      push(fw);
    end
    n_scnt = m_scnt + 16'(e_stall);
    n_fcnt = m_fcnt + 16'(e_flush);
  endtask

  task automatic model_commit(input bit rst);
    if (rst) begin
      m_pipe = '{NOP, NOP, NOP};
      m_halted = 1;
      m_flush_left = 0;
      m_drain_left = 0;
      m_scnt = 16'd0;
      m_fcnt = 16'd0;
    end else begin
      m_pipe = n_pipe;
      m_halted = n_halted;
      m_flush_left = n_flush_left;
      m_drain_left = n_drain_left;
      m_scnt = n_scnt;
      m_fcnt = n_fcnt;
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit later, compare against the model, advance the model.
  task automatic cycle(input bit st, input logic [15:0] fw, input bit bt, input bit rst, input bit chk);
    @(negedge clk);
    start = st; fetch_word = fw; branch_taken = bt; reset = rst;
    #1;
    model_eval(st, fw, bt);
    s_cmd = COMMAND; s_bef = BeforeCOMMAND; s_two = TwoBeforeCOMMAND;
    s_pcen = pc_en; s_sel = pc_load_sel; s_stall = stall; s_flush = flush; s_halted = halted;
    $display("cyc=%0d rst=%0d start=%0d fetch=%h bt=%0d | C=%h B=%h T=%h pc_en=%0d sel=%0d stall=%0d flush=%0d halted=%0d",
             cyc, rst, st, fw, bt, s_cmd, s_bef, s_two, s_pcen, s_sel, s_stall, s_flush, s_halted);
    if (chk) begin
      check("COMMAND", s_cmd, m_pipe[0]);
      check("BeforeCOMMAND", s_bef, m_pipe[1]);
      check("TwoBeforeCOMMAND", s_two, m_pipe[2]);
      check("pc_en", 16'(s_pcen), 16'(e_pcen));
      check("pc_load_sel", 16'(s_sel), 16'(e_sel));
      check("stall", 16'(s_stall), 16'(e_stall));
      check("flush", 16'(s_flush), 16'(e_flush));
      check("halted", 16'(s_halted), 16'(e_halted));
`ifdef PIPECTL_PERF_CNT_EN
      check("stall_count", stall_count, m_scnt);
      check("flush_count", flush_count, m_fcnt);
`endif
    end
    model_commit(rst);
    cyc++;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    int unsigned k;
    w = 16'($urandom);
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2: w[15:14] = 2'b00;
      3, 4, 5: w[15:14] = 2'b11;
      6:       w[15:14] = 2'b01;
      7:       w[15:11] = 5'b10100;
      8:       w[15:11] = 5'b10111;
      default: begin w[15:14] = 2'b11; w[7:4] = 4'hF; end
    endcase
    return w;
  endfunction

  logic        r_start, r_taken, r_reset;
  logic [15:0] r_word;

  initial begin
    reset = 1'b1; start = 1'b0; fetch_word = 16'h0; branch_taken = 1'b0;
    m_pipe = '{NOP, NOP, NOP};
    m_halted = 1; m_flush_left = 0; m_drain_left = 0; m_scnt = 0; m_fcnt = 0;

    // Reset state
    cycle(0, 16'h0000, 0, 1, 0);
    cycle(0, 16'h0000, 0, 1, 1);
    check("rst_halted", 16'(s_halted), 16'd1);
    check("rst_cmd", s_cmd, NOP);
    check("rst_two", s_two, NOP);
    check("rst_pc_en", 16'(s_pcen), 16'd0);

    // Start and fill
    cycle(1, 16'h0000, 0, 0, 1);
    cycle(0, 16'h0801, 0, 0, 1);
    check("start_halted", 16'(s_halted), 16'd0);
    check("start_pc_en", 16'(s_pcen), 16'd1);
    cycle(0, 16'h1002, 0, 0, 1);
    cycle(0, 16'hC000, 0, 0, 1);
    cycle(0, 16'hC000, 0, 0, 1);
    check("fill_two", s_two, 16'h0801);
    check("fill_bef", s_bef, 16'h1002);
    check("fill_cmd", s_cmd, 16'hC000);

    // Load-use bubble
    cycle(0, 16'h0900, 0, 0, 1);
    cycle(0, 16'hC100, 0, 0, 1);
    cycle(0, 16'hC000, 0, 0, 1);
    check("lu_stall", 16'(s_stall), 16'd1);
    check("lu_pc_en", 16'(s_pcen), 16'd0);
    cycle(0, 16'hC000, 0, 0, 1);
    check("lu_stall_once", 16'(s_stall), 16'd0);
    check("lu_cmd_held", s_cmd, 16'hC100);
    check("lu_bef_nop", s_bef, NOP);
    check("lu_resume_pc_en", 16'(s_pcen), 16'd1);

    // Taken branch with two flush cycles
    cycle(0, 16'hA000, 0, 0, 1);
    cycle(0, 16'h1111, 1, 0, 1);
    check("br_sel", 16'(s_sel), 16'd1);
    check("br_flush", 16'(s_flush), 16'd1);
    cycle(0, 16'h2222, 1, 0, 1);
    check("fl_cmd", s_cmd, NOP);
    check("fl_flush", 16'(s_flush), 16'd1);
    check("fl_sel", 16'(s_sel), 16'd0);
    check("fl_pc_en", 16'(s_pcen), 16'd1);
    cycle(0, 16'hC000, 0, 0, 1);
    check("fl_cmd2", s_cmd, NOP);
    check("fl_done", 16'(s_flush), 16'd0);

    // HLT, drain, halt, restart
    cycle(0, 16'hC0F0, 0, 0, 1);
    cycle(0, 16'hC000, 0, 0, 1);
    check("hlt_cmd", s_cmd, 16'hC0F0);
    check("hlt_pc_en", 16'(s_pcen), 16'd0);
    cycle(0, 16'hC000, 0, 0, 1);
    check("drain_halted", 16'(s_halted), 16'd0);
    check("drain_pc_en", 16'(s_pcen), 16'd0);
    cycle(0, 16'hC000, 0, 0, 1);
    cycle(0, 16'hC000, 0, 0, 1);
    check("halt_halted", 16'(s_halted), 16'd1);
    cycle(1, 16'hC000, 0, 0, 1);
    check("halt_pc_en", 16'(s_pcen), 16'd0);
    cycle(0, 16'hC000, 0, 0, 1);
    check("restart_halted", 16'(s_halted), 16'd0);

    // Reset in the middle of FLUSH
    cycle(0, 16'hA000, 0, 0, 1);
    cycle(0, 16'h3333, 1, 0, 1);
    cycle(0, 16'h4444, 0, 1, 1);
    check("mr_in_flush", 16'(s_flush), 16'd1);
    cycle(0, 16'hC000, 0, 0, 1);
    check("mr_halted", 16'(s_halted), 16'd1);
    check("mr_cmd", s_cmd, NOP);
    check("mr_bef", s_bef, NOP);
    check("mr_two", s_two, NOP);
`ifdef PIPECTL_PERF_CNT_EN
    check("mr_stall_count", stall_count, 16'd0);
    check("mr_flush_count", flush_count, 16'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      r_start = ($urandom_range(0, 2) == 0);
      r_taken = 1'($urandom_range(0, 1));
      r_reset = ($urandom_range(0, 59) == 0);
      r_word  = rand_word();
      cycle(r_start, r_word, r_taken, r_reset, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
